// File: rtl/jtdsp16_rom_arb.sv
// ---------------------------------------------------------------------------
// jtdsp16_rom_arb
//
// Purpose:
//   Arbitrates the single external program ROM port between instruction
//   fetches (XAAU program counter) and table reads (pt pointer). Table reads
//   win when both are pending. A one-entry line cache holds the most recently
//   fetched instruction word, so a repeated fetch to the same address is
//   answered without touching the external ROM. Each external access is
//   bounded by a wait counter. When the counter expires, the requester
//   receives 16'hFFFF and a sticky timeout flag is raised.
//
// Ports:
//   clk, rst_n              - clock and asynchronous active-low reset
//   fetch_req/fetch_addr    - level fetch request, held until fetch_valid
//   table_req/table_addr    - level table request, held until table_valid
//   flush                   - invalidates the fetch line cache
//   ext_addr/ext_cs         - external ROM address and access strobe
//   ext_data/ext_ok         - external ROM data and data-valid handshake
//   fetch_data/fetch_valid  - fetched word and its one-cycle valid pulse
//   table_data/table_valid  - table word and its one-cycle valid pulse
//   stall                   - core clock-enable inhibit while any request waits
//   tout_err                - sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module jtdsp16_rom_arb #(
  parameter int TOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        table_req,
  input  logic [15:0] table_addr,
  input  logic        flush,
  output logic [15:0] ext_addr,
  output logic        ext_cs,
  input  logic [15:0] ext_data,
  input  logic        ext_ok,
  output logic [15:0] fetch_data,
  output logic        fetch_valid,
  output logic [15:0] table_data,
  output logic        table_valid,
  output logic        stall,
  output logic        tout_err
);

  typedef enum logic [1:0] {IDLE, FETCH, TABLE, DONE} state_t;

  // The last waiting cycle has count TOUT-1. The access therefore ends after
  // exactly TOUT cycles with ext_cs high.
  localparam logic [15:0] TOUT_LAST = 16'(TOUT - 1);

  state_t      state_q, state_d;
  logic        ext_cs_q, ext_cs_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [15:0] fetch_data_q, fetch_data_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [15:0] table_data_q, table_data_d;
  logic        table_valid_q, table_valid_d;
  logic        tout_err_q, tout_err_d;
  logic        line_valid_q, line_valid_d;
  logic [15:0] line_tag_q, line_tag_d;
  logic [15:0] line_data_q, line_data_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic fetch_pend;
  logic table_pend;
  logic cache_hit;

  // A request whose valid pulse is currently visible counts as served. The
  // requester drops it on this edge, so the request must not be accepted a
  // second time.
  assign fetch_pend = fetch_req & ~fetch_valid_q;
  assign table_pend = table_req & ~table_valid_q;

  // A lookup made in the same cycle as a flush counts as a miss.
  assign cache_hit = line_valid_q & (line_tag_q == fetch_addr) & ~flush;

  always_comb begin
    state_d       = state_q;
    ext_cs_d      = ext_cs_q;
    ext_addr_d    = ext_addr_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    table_data_d  = table_data_q;
    table_valid_d = 1'b0;
    tout_err_d    = tout_err_q;
    line_valid_d  = line_valid_q;
    line_tag_d    = line_tag_q;
    line_data_d   = line_data_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (table_pend) begin
          state_d    = TABLE;
          ext_cs_d   = 1'b1;
          ext_addr_d = table_addr;
          wait_cnt_d = 16'd0;
        end else if (fetch_pend) begin
          if (cache_hit) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = line_data_q;
          end else begin
            state_d    = FETCH;
            ext_cs_d   = 1'b1;
            ext_addr_d = fetch_addr;
            wait_cnt_d = 16'd0;
          end
        end
      end

      FETCH, TABLE: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (ext_ok) begin
          state_d  = DONE;
          ext_cs_d = 1'b0;
          if (state_q == FETCH) begin
            fetch_data_d  = ext_data;
            fetch_valid_d = 1'b1;
            line_valid_d  = 1'b1;
            line_tag_d    = ext_addr_q;
            line_data_d   = ext_data;
          end else begin
            table_data_d  = ext_data;
            table_valid_d = 1'b1;
          end
        end else if (wait_cnt_q == TOUT_LAST) begin
          state_d    = DONE;
          ext_cs_d   = 1'b0;
          tout_err_d = 1'b1;
          if (state_q == FETCH) begin
            fetch_data_d  = 16'hFFFF;
            fetch_valid_d = 1'b1;
          end else begin
            table_data_d  = 16'hFFFF;
            table_valid_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        ext_cs_d = 1'b0;
      end
    endcase

    // A flush overrides a line fill made on the same edge.
    if (flush) begin
      line_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ext_cs_q      <= 1'b0;
      ext_addr_q    <= 16'd0;
      fetch_data_q  <= 16'd0;
      fetch_valid_q <= 1'b0;
      table_data_q  <= 16'd0;
      table_valid_q <= 1'b0;
      tout_err_q    <= 1'b0;
      line_valid_q  <= 1'b0;
      line_tag_q    <= 16'd0;
      line_data_q   <= 16'd0;
      wait_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      ext_cs_q      <= ext_cs_d;
      ext_addr_q    <= ext_addr_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      table_data_q  <= table_data_d;
      table_valid_q <= table_valid_d;
      tout_err_q    <= tout_err_d;
      line_valid_q  <= line_valid_d;
      line_tag_q    <= line_tag_d;
      line_data_q   <= line_data_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign ext_cs      = ext_cs_q;
  assign ext_addr    = ext_addr_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign table_data  = table_data_q;
  assign table_valid = table_valid_q;
  assign tout_err    = tout_err_q;
  assign stall       = (fetch_req & ~fetch_valid_q) | (table_req & ~table_valid_q);

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// ---------------------------------------------------------------------------
// tb_jtdsp16_rom_arb
//
// Directed testbench for jtdsp16_rom_arb. Inputs are driven on the falling
// clock edge. Outputs are sampled on the falling edge, before the inputs are
// changed.
// ---------------------------------------------------------------------------
module tb_jtdsp16_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        table_req;
  logic [15:0] table_addr;
  logic        flush;
  logic [15:0] ext_addr;
  logic        ext_cs;
  logic [15:0] ext_data;
  logic        ext_ok;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic [15:0] table_data;
  logic        table_valid;
  logic        stall;
  logic        tout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtdsp16_rom_arb #(.TOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .table_req   (table_req),
    .table_addr  (table_addr),
    .flush       (flush),
    .ext_addr    (ext_addr),
    .ext_cs      (ext_cs),
    .ext_data    (ext_data),
    .ext_ok      (ext_ok),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .table_data  (table_data),
    .table_valid (table_valid),
    .stall       (stall),
    .tout_err    (tout_err)
  );

  // Reset values of every output, checked after the asynchronous reset.
  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 16'd0; table_req = 1'b0;
    table_addr = 16'd0; flush = 1'b0; ext_data = 16'd0; ext_ok = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ext_cs !== 1'b0) begin bad++; $display("[TB] FAIL reset_ext_cs got=%b want=0", ext_cs); end
    total++; if (ext_addr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_ext_addr got=%h want=0000", ext_addr); end
    total++; if (fetch_valid !== 1'b0 || table_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valids got=%b%b want=00", fetch_valid, table_valid); end
    total++; if (fetch_data !== 16'h0000 || table_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data got=%h/%h want=0000/0000", fetch_data, table_data); end
    total++; if (tout_err !== 1'b0 || stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags tout_err=%b stall=%b want=0/0", tout_err, stall); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Miss to 0x0100. ext_ok is given in the third strobe cycle.
  task automatic test_fetch_miss();
    int cs_cnt = 0;
    bit got = 0;
    fetch_addr = 16'h0100; fetch_req = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL miss_stall_pending got=%b want=1", stall); end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        got = 1;
        total++; if (fetch_data !== 16'h4A21) begin bad++; $display("[TB] FAIL miss_data got=%h want=4a21", fetch_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL miss_stall_served got=%b want=0", stall); end
        total++; if (ext_cs !== 1'b0) begin bad++; $display("[TB] FAIL miss_cs_drop got=%b want=0", ext_cs); end
        fetch_req = 1'b0; ext_ok = 1'b0;
      end else if (ext_cs) begin
        cs_cnt++;
        total++; if (ext_addr !== 16'h0100) begin bad++; $display("[TB] FAIL miss_addr got=%h want=0100", ext_addr); end
        ext_data = 16'h4A21;
        ext_ok = (cs_cnt == 3);
      end
    end
    total++; if (!got) begin bad++; $display("[TB] FAIL miss_timeout got=no_valid want=valid"); end
    total++; if (cs_cnt != 3) begin bad++; $display("[TB] FAIL miss_cs_cycles got=%0d want=3", cs_cnt); end
    @(negedge clk);
    total++; if (fetch_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("[TB] FAIL miss_single_pulse valid=%b stall=%b want=0/0", fetch_valid, stall); end
  endtask

  // Repeat of 0x0100 is answered from the line cache on the next cycle.
  task automatic test_fetch_hit();
    fetch_addr = 16'h0100; fetch_req = 1'b1;
    @(negedge clk);
    total++; if (fetch_valid !== 1'b1 || fetch_data !== 16'h4A21) begin bad++; $display("[TB] FAIL hit_valid valid=%b data=%h want=1/4a21", fetch_valid, fetch_data); end
    total++; if (ext_cs !== 1'b0) begin bad++; $display("[TB] FAIL hit_no_cs got=%b want=0", ext_cs); end
    fetch_req = 1'b0;
    @(negedge clk);
    total++; if (fetch_valid !== 1'b0 || ext_cs !== 1'b0) begin bad++; $display("[TB] FAIL hit_after valid=%b cs=%b want=0/0", fetch_valid, ext_cs); end
  endtask

  // Simultaneous table and fetch requests are served table first.
  task automatic test_priority();
    int first_addr = -1;
    int order = 0;
    bit tdone = 0, fdone = 0;
    fetch_addr = 16'h0200; table_addr = 16'h0800;
    fetch_req = 1'b1; table_req = 1'b1;
    for (int i = 0; i < 60 && !(tdone && fdone); i++) begin
      @(negedge clk);
      if (ext_cs && first_addr < 0) first_addr = int'(ext_addr);
      if (table_valid) begin
        tdone = 1; order = order * 10 + 1;
        total++; if (table_data !== 16'h1234) begin bad++; $display("[TB] FAIL prio_table_data got=%h want=1234", table_data); end
        table_req = 1'b0;
      end
      if (fetch_valid) begin
        fdone = 1; order = order * 10 + 2;
        total++; if (fetch_data !== 16'h5678) begin bad++; $display("[TB] FAIL prio_fetch_data got=%h want=5678", fetch_data); end
        fetch_req = 1'b0;
      end
      ext_data = (ext_addr == 16'h0800) ? 16'h1234 : 16'h5678;
      ext_ok = ext_cs;
    end
    ext_ok = 1'b0;
    total++; if (first_addr != 32'h0800) begin bad++; $display("[TB] FAIL prio_first_addr got=%h want=0800", first_addr); end
    total++; if (order != 12) begin bad++; $display("[TB] FAIL prio_order got=%0d want=12", order); end
    @(negedge clk);
  endtask

  // ext_ok never comes. The strobe lasts 15 cycles, then FFFF is returned
  // and the sticky error is raised.
  task automatic test_timeout();
    int cs_cnt = 0;
    bit got = 0;
    total++; if (tout_err !== 1'b0) begin bad++; $display("[TB] FAIL tout_pre got=%b want=0", tout_err); end
    fetch_addr = 16'h0300; fetch_req = 1'b1; ext_ok = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        got = 1;
        total++; if (fetch_data !== 16'hFFFF) begin bad++; $display("[TB] FAIL tout_data got=%h want=ffff", fetch_data); end
        total++; if (tout_err !== 1'b1) begin bad++; $display("[TB] FAIL tout_flag got=%b want=1", tout_err); end
        fetch_req = 1'b0;
      end else if (ext_cs) begin
        cs_cnt++;
      end
    end
    total++; if (!got || cs_cnt != 15) begin bad++; $display("[TB] FAIL tout_cycles got=%0d want=15", cs_cnt); end
    repeat (5) @(negedge clk);
    total++; if (tout_err !== 1'b1) begin bad++; $display("[TB] FAIL tout_sticky got=%b want=1", tout_err); end
  endtask

  // Runs one fetch and reports whether the external port was used. The
  // external ROM answers immediately. flush_on_ok asserts flush at the
  // completion edge. flush_first asserts flush in the first lookup cycle.
  task automatic do_fetch(input logic [15:0] a, input logic [15:0] d,
                          input bit flush_on_ok, input bit flush_first,
                          output bit used_ext, output bit got);
    used_ext = 0; got = 0;
    fetch_addr = a; fetch_req = 1'b1; flush = flush_first;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (fetch_valid) begin
        got = 1; fetch_req = 1'b0; ext_ok = 1'b0;
      end else begin
        if (ext_cs) used_ext = 1;
        ext_data = d; ext_ok = ext_cs;
        if (ext_cs && flush_on_ok) flush = 1'b1;
      end
    end
    ext_ok = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  // Flush wins over a line fill on the same edge. A lookup in a flush cycle
  // misses.
  task automatic test_flush();
    bit used, got;
    do_fetch(16'h0400, 16'hBEEF, 1, 0, used, got);
    total++; if (!got || !used) begin bad++; $display("[TB] FAIL flush_fill got=%0d used=%0d want=1/1", got, used); end
    do_fetch(16'h0400, 16'hBEEF, 0, 0, used, got);
    total++; if (!got || !used) begin bad++; $display("[TB] FAIL flush_coincident_miss got=%0d used=%0d want=1/1", got, used); end
    total++; if (fetch_data !== 16'hBEEF) begin bad++; $display("[TB] FAIL flush_refill_data got=%h want=beef", fetch_data); end
    do_fetch(16'h0400, 16'hBEEF, 0, 1, used, got);
    total++; if (!got || !used) begin bad++; $display("[TB] FAIL flush_lookup_miss got=%0d used=%0d want=1/1", got, used); end
    do_fetch(16'h0400, 16'hBEEF, 0, 0, used, got);
    total++; if (!got || used) begin bad++; $display("[TB] FAIL flush_rehit got=%0d used=%0d want=1/0", got, used); end
  endtask

  // Reset in the middle of an access drops the strobe at once. No valid
  // pulse follows the release.
  task automatic test_reset_mid();
    bit seen = 0;
    int cs_cnt = 0;
    fetch_addr = 16'h0500; fetch_req = 1'b1; ext_ok = 1'b0;
    for (int i = 0; i < 20 && cs_cnt < 2; i++) begin
      @(negedge clk);
      if (ext_cs) cs_cnt++;
    end
    total++; if (cs_cnt != 2) begin bad++; $display("[TB] FAIL rstmid_start got=%0d want=2", cs_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ext_cs !== 1'b0 || ext_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rstmid_cs cs=%b addr=%h want=0/0000", ext_cs, ext_addr); end
    total++; if (tout_err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_tout got=%b want=0", tout_err); end
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_valid || table_valid || ext_cs) seen = 1;
    end
    total++; if (seen) begin bad++; $display("[TB] FAIL rstmid_no_valid got=activity want=none"); end
  endtask

  initial begin
    test_reset();
    test_fetch_miss();
    test_fetch_hit();
    test_priority();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
